// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch stage: NOP encoding,
// default reset vector and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: reset vector load, word-aligned redirect, and +4 advance
// (wrapping modulo 2^32).
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~32'h3;
        end else if (advance) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, an IF/ID output
// register with a one-entry hold buffer, and redirect/flush handling.
//
// Handshake: imem_req is a one-cycle strobe with imem_addr; exactly one
// imem_ack answers each request. The IF/ID register transfers to decode on
// any cycle with if_valid=1 and stall_in=0; while stalled it is held stable.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_in,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic         if_valid,
    output logic [31:0]  if_inst,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_pc_plus4,
    output fetch_state_e dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc;
    logic [31:0]  hold_q;
    logic [31:0]  if_inst_q;
    logic [31:0]  if_pc_q;
    logic         if_valid_q;
    logic         advance;
    logic         load_mem;
    logic         load_hold;
    logic         capture_hold;
    logic         out_free;

    assign out_free = !if_valid_q || !stall_in;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc             (pc)
    );

    always_comb begin
        state_d      = state_q;
        advance      = 1'b0;
        load_mem     = 1'b0;
        load_hold    = 1'b0;
        capture_hold = 1'b0;
        case (state_q)
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_ack) begin
                    if (out_free) begin
                        load_mem = 1'b1;
                        advance  = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        capture_hold = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall_in) begin
                    load_hold = 1'b1;
                    advance   = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_DRAIN: if (imem_ack) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
        // A redirect cancels every load; only a still-pending request forces DRAIN.
        if (redirect_valid) begin
            advance      = 1'b0;
            load_mem     = 1'b0;
            load_hold    = 1'b0;
            capture_hold = 1'b0;
            if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !imem_ack) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_q <= 1'b0;
            if_inst_q  <= NOP_INST;
            if_pc_q    <= 32'h0;
            hold_q     <= 32'h0;
        end else if (redirect_valid) begin
            if_valid_q <= 1'b0;
            hold_q     <= 32'h0;
        end else begin
            if (capture_hold) hold_q <= imem_rdata;
            if (load_mem || load_hold) begin
                if_valid_q <= 1'b1;
                if_inst_q  <= load_hold ? hold_q : imem_rdata;
                if_pc_q    <= pc;
            end else if (if_valid_q && !stall_in) begin
                if_valid_q <= 1'b0;
            end
        end
    end

    // A redirect in FETCH suppresses the strobe so no stale request is left in flight.
    assign imem_req    = (state_q == ST_FETCH) && !rst && !redirect_valid;
    assign imem_addr   = pc;
    assign if_valid    = if_valid_q;
    assign if_inst     = if_inst_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + 32'd4;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle table for the directed corner cases, then a
// randomized run against a program-order stream model and a scripted memory.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall_in;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic         if_valid;
    logic [31:0]  if_inst;
    logic [31:0]  if_pc;
    logic [31:0]  if_pc_plus4;
    fetch_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h100)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .dbg_state      (dbg_state)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic apply(input logic r, input logic s, input logic v, input logic [31:0] p,
                         input logic a, input logic [31:0] d);
        @(negedge clk);
        rst = r; stall_in = s; redirect_valid = v; redirect_pc = p;
        imem_ack = a; imem_rdata = d;
        #1;
    endtask

    typedef struct {
        logic         rst, stall, redir;
        logic [31:0]  rpc;
        logic         ack;
        logic [31:0]  rdata;
        logic         exp_req;
        logic [31:0]  exp_addr;
        fetch_state_e exp_state;
        logic         exp_valid;
        logic [31:0]  exp_pc, exp_inst;
    } vec_t;

    function automatic vec_t vr(input logic r, s, v, input logic [31:0] p, input logic a,
                                input logic [31:0] d, input logic q, input logic [31:0] qa,
                                input fetch_state_e st, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t t;
        t.rst = r; t.stall = s; t.redir = v; t.rpc = p; t.ack = a; t.rdata = d;
        t.exp_req = q; t.exp_addr = qa; t.exp_state = st; t.exp_valid = ev;
        t.exp_pc = ep; t.exp_inst = ei;
        return t;
    endfunction

    vec_t tbl[32];

    logic        st, rv, ak;
    logic [31:0] rpc, rd;
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic [31:0] exp_pc;
    logic        prev_hold;
    logic [31:0] prev_pc, prev_inst;
    int          consumed, idle, max_idle;

    initial begin
        tbl[0]  = vr(1,0,0,0,0,0,                    0,0,ST_FETCH,0,32'h0,NOP_INST);
        tbl[1]  = vr(0,0,0,0,0,0,                    1,32'h100,ST_FETCH,0,0,0);
        tbl[2]  = vr(0,0,0,0,1,mem_word(32'h100),    0,0,ST_WAIT,0,0,0);
        tbl[3]  = vr(0,0,0,0,0,0,                    1,32'h104,ST_FETCH,1,32'h100,mem_word(32'h100));
        tbl[4]  = vr(0,0,0,0,1,mem_word(32'h104),    0,0,ST_WAIT,0,0,0);
        tbl[5]  = vr(0,0,0,0,0,0,                    1,32'h108,ST_FETCH,1,32'h104,mem_word(32'h104));
        tbl[6]  = vr(0,0,0,0,1,mem_word(32'h108),    0,0,ST_WAIT,0,0,0);
        tbl[7]  = vr(0,1,0,0,0,0,                    1,32'h10C,ST_FETCH,1,32'h108,mem_word(32'h108));
        tbl[8]  = vr(0,1,0,0,1,mem_word(32'h10C),    0,0,ST_WAIT,1,32'h108,mem_word(32'h108));
        tbl[9]  = vr(0,1,0,0,0,0,                    0,0,ST_HOLD,1,32'h108,mem_word(32'h108));
        tbl[10] = vr(0,1,0,0,0,0,                    0,0,ST_HOLD,1,32'h108,mem_word(32'h108));
        tbl[11] = vr(0,1,0,0,0,0,                    0,0,ST_HOLD,1,32'h108,mem_word(32'h108));
        tbl[12] = vr(0,0,0,0,0,0,                    0,0,ST_HOLD,1,32'h108,mem_word(32'h108));
        tbl[13] = vr(0,0,0,0,0,0,                    1,32'h110,ST_FETCH,1,32'h10C,mem_word(32'h10C));
        tbl[14] = vr(0,0,1,32'h2003,0,0,             0,0,ST_WAIT,0,0,0);
        tbl[15] = vr(0,0,0,0,0,0,                    0,0,ST_DRAIN,0,0,0);
        tbl[16] = vr(0,0,0,0,0,0,                    0,0,ST_DRAIN,0,0,0);
        tbl[17] = vr(0,0,0,0,1,mem_word(32'h110),    0,0,ST_DRAIN,0,0,0);
        tbl[18] = vr(0,0,0,0,0,0,                    1,32'h2000,ST_FETCH,0,0,0);
        tbl[19] = vr(0,0,0,0,1,mem_word(32'h2000),   0,0,ST_WAIT,0,0,0);
        tbl[20] = vr(0,1,0,0,0,0,                    1,32'h2004,ST_FETCH,1,32'h2000,mem_word(32'h2000));
        tbl[21] = vr(0,1,1,32'hFFFF_FFFC,1,mem_word(32'h2004), 0,0,ST_WAIT,1,32'h2000,mem_word(32'h2000));
        tbl[22] = vr(0,0,0,0,0,0,                    1,32'hFFFF_FFFC,ST_FETCH,0,0,0);
        tbl[23] = vr(0,0,0,0,1,mem_word(32'hFFFF_FFFC), 0,0,ST_WAIT,0,0,0);
        tbl[24] = vr(0,0,0,0,0,0,                    1,32'h0,ST_FETCH,1,32'hFFFF_FFFC,mem_word(32'hFFFF_FFFC));
        tbl[25] = vr(0,0,0,0,1,mem_word(32'h0),      0,0,ST_WAIT,0,0,0);
        tbl[26] = vr(0,0,0,0,0,0,                    1,32'h4,ST_FETCH,1,32'h0,mem_word(32'h0));
        tbl[27] = vr(1,0,0,0,0,0,                    0,0,ST_WAIT,0,0,0);
        tbl[28] = vr(0,0,0,0,1,32'hDEAD_BEEF,        1,32'h100,ST_FETCH,0,0,0);
        tbl[29] = vr(0,0,0,0,0,0,                    0,0,ST_WAIT,0,0,0);
        tbl[30] = vr(0,0,0,0,1,mem_word(32'h100),    0,0,ST_WAIT,0,0,0);
        tbl[31] = vr(0,0,0,0,0,0,                    1,32'h104,ST_FETCH,1,32'h100,mem_word(32'h100));

        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) begin
            apply(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].ack, tbl[i].rdata);
            chk($sformatf("r%0d_imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req) chk($sformatf("r%0d_imem_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("r%0d_state", i), {30'b0, dbg_state}, {30'b0, tbl[i].exp_state});
            chk($sformatf("r%0d_if_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid || i == 0) begin
                chk($sformatf("r%0d_if_pc", i), if_pc, tbl[i].exp_pc);
                chk($sformatf("r%0d_if_inst", i), if_inst, tbl[i].exp_inst);
                chk($sformatf("r%0d_if_pc_plus4", i), if_pc_plus4, tbl[i].exp_pc + 32'd4);
            end
        end

        // Randomized run: delivered words must follow program order from the
        // last redirect target (or the reset vector), with no gaps or repeats.
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        exp_pc = 32'h100; prev_hold = 1'b0; prev_pc = 0; prev_inst = 0;
        consumed = 0; idle = 0; max_idle = 0;
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom_range(0, 9) < 3);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF9 : $urandom;
            ak  = 1'b0;
            rd  = $urandom;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    ak = 1'b1;
                    rd = mem_word(mem_addr);
                    mem_pend = 1'b0;
                end
            end
            apply(0, st, rv, rpc, ak, rd);
            if (prev_hold) begin
                chk("stall_valid_held", {31'b0, if_valid}, 32'd1);
                chk("stall_pc_held", if_pc, prev_pc);
                chk("stall_inst_held", if_inst, prev_inst);
            end
            if (if_valid && !st && !rv) begin
                chk("stream_pc", if_pc, exp_pc);
                chk("stream_inst", if_inst, mem_word(exp_pc));
                chk("stream_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (rv) exp_pc = rpc & ~32'h3;
            prev_hold = if_valid && st && !rv;
            prev_pc   = if_pc;
            prev_inst = if_inst;
            if (imem_req) begin
                chk("one_outstanding", {31'b0, mem_pend}, 32'd0);
                mem_pend = 1'b1;
                mem_cnt  = $urandom_range(1, 3);
                mem_addr = imem_addr;
            end
            idle = if_valid ? 0 : idle + 1;
            if (idle > max_idle) max_idle = idle;
        end
        chk("progress_min_consumed", {31'b0, consumed > 200}, 32'd1);
        chk("progress_max_idle", {31'b0, max_idle <= 40}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port stall_in, input, 1 bit: decode not ready; the held instruction is not consumed this cycle.
REQ-005 SHALL have port redirect_valid, input, 1 bit: branch, JAL or JALR taken; flush and refetch.
REQ-006 SHALL have port redirect_pc, input, 32 bits: target address; bits [1:0] are ignored and treated as 00.
REQ-007 SHALL have port imem_req, output, 1 bit: one-cycle fetch request strobe.
REQ-008 SHALL have port imem_addr, output, 32 bits: word-aligned fetch address, valid when imem_req=1.
REQ-009 SHALL have port imem_ack, input, 1 bit: returned data valid, one or more cycles after imem_req.
REQ-010 SHALL have port imem_rdata, input, 32 bits: instruction word, valid with imem_ack.
REQ-011 SHALL have port if_valid, output, 1 bit: the IF/ID register holds a live instruction.
REQ-012 SHALL have port if_inst, output, 32 bits: instruction word delivered to decode and the immediate generator.
REQ-013 SHALL have port if_pc, output, 32 bits: address of if_inst.
REQ-014 SHALL have port if_pc_plus4, output, 32 bits: if_pc+4, modulo 2^32.

Function
REQ-015 SHALL implement the states FETCH, WAIT, HOLD and DRAIN, with at most one memory request outstanding.
REQ-016 FETCH SHALL drive imem_req=1 and imem_addr=pc for exactly one cycle, then move to WAIT.
REQ-017 WAIT SHALL drive imem_req=0, and on imem_ack SHALL do one of the following:
- if the output register is free (if_valid=0 or stall_in=0), load if_inst/if_pc, set if_valid=1, set pc=pc+4, and move to FETCH;
- otherwise, store imem_rdata in a hold buffer and move to HOLD.
REQ-018 HOLD SHALL keep imem_req=0; when stall_in=0, it SHALL load the output register from the hold buffer, set pc=pc+4, and move to FETCH.
REQ-019 if_valid SHALL clear on the cycle after consumption (if_valid=1 and stall_in=0) if no new instruction is loaded in that same cycle.
REQ-020 While stall_in=1 and if_valid=1, if_inst, if_pc and if_pc_plus4 SHALL remain stable.
REQ-021 Minimum latency SHALL be: imem_req at cycle t, imem_ack at t+1, if_valid=1 at t+2; peak throughput is one instruction per 2 cycles.
REQ-022 redirect_valid SHALL take priority over every other event, including stall_in. On the next edge it SHALL set if_valid=0, discard the hold buffer, and set pc={redirect_pc[31:2],2'b00}.
REQ-023 After a redirect, the next state SHALL be:
- FETCH from FETCH, from HOLD, or from WAIT when imem_ack is high in the same cycle (the returned data is discarded);
- DRAIN from WAIT when imem_ack is low.
REQ-024 DRAIN SHALL discard the next imem_ack and then move to FETCH; a further redirect in DRAIN SHALL update pc and stay in DRAIN.
REQ-025 imem_ack received in FETCH or HOLD SHALL be ignored.
REQ-026 pc+4 SHALL wrap modulo 2^32; 32'hFFFF_FFFC is followed by 32'h0000_0000.

Reset
REQ-027 While rst=1, on each edge the block SHALL set: pc=RESET_PC, state=FETCH, if_valid=0, if_inst=32'h0000_0013 (NOP), if_pc=32'h0, hold buffer=0.
REQ-028 While rst=1, outputs SHALL be: imem_req=0 and if_pc_plus4=32'h4.
REQ-029 The first imem_req SHALL occur in the first cycle with rst=0.
REQ-030 A reset applied mid-request SHALL abandon the outstanding request; any late ack is covered by REQ-025.

Structure
REQ-031 A shared CPU package SHALL hold the NOP constant (32'h0000_0013), the RESET_PC default and the fetch state encoding.
REQ-032 The PC register with its +4 and redirect multiplexer SHALL be one sub-module, pc_reg; everything else stays in fetch_unit.

Verification
REQ-033 Reset with RESET_PC=32'h100, memory acking in 1 cycle, no stall: imem_addr sequence 100,104,108; if_inst appears 2 cycles after each imem_req; if_pc_plus4=if_pc+4.
REQ-034 stall_in=1 for 5 cycles while if_valid=1 and a fetch acks: FSM enters HOLD; if_inst unchanged; after stall release the buffered word appears next cycle with no loss or duplication.
REQ-035 redirect_valid with redirect_pc=32'h0000_2003 while in WAIT, ack 3 cycles later: if_valid=0 next cycle; late data discarded; next imem_addr=32'h0000_2000.
REQ-036 redirect_valid and imem_ack in the same WAIT cycle with stall_in=1: data dropped, if_valid=0, FETCH of the target next cycle.
REQ-037 pc starts at 32'hFFFF_FFFC: fetches FFFF_FFFC then 0000_0000; if_pc_plus4=0 for the first.
REQ-038 rst asserted one cycle during WAIT, stray ack after release: ack ignored; if_valid=0 until the RESET_PC fetch returns.
